// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, fetch-unit state enum and opcode constants for the CPU front end
package cpu_pkg;
  localparam int INSTR_W = 32;
  localparam int OPCODE_W = 6;
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DRAIN} ifu_state_t;
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J = 6'b000010;
endpackage

// File: rtl/ifu_perf_counters.sv
// ifu_perf_counters: wrapping 32-bit delivered/flushed counters; in clk, rst, i_fetch_inc, i_flush_inc; out o_fetch_cnt, o_flush_cnt
module ifu_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fetch_inc,
  input  logic        i_flush_inc,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_flush_cnt
);
  always_ff @(posedge clk) begin
    if (rst) begin
      o_fetch_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      o_fetch_cnt <= o_fetch_cnt + 32'(i_fetch_inc);
      o_flush_cnt <= o_flush_cnt + 32'(i_flush_inc);
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC + req/ack imem fetch + valid/ready decode issue with redirect flush; ports clk, rst, imem_*, dec_*, redirect_*, perf_* counters when IFU_PERF_CNT_EN is defined
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                dec_valid,
  input  logic                dec_ready,
  output logic [INSTR_W-1:0]  dec_instr,
  output logic [OPCODE_W-1:0] dec_opcode,
  output logic [ADDR_W-1:0]   dec_pc,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_flush_cnt
`endif
);
  ifu_state_t r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt, r_addr, r_dec_pc, w_tgt;
  logic [INSTR_W-1:0] r_instr;
  logic w_hs, w_cap;
  assign w_tgt = redirect_pc & ~ADDR_W'(3);
  assign w_hs = (r_state == ISSUE) && dec_ready;
  assign w_cap = (r_state == FETCH) && imem_ack && !redirect_valid;
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt = redirect_valid ? w_tgt : w_cap ? r_pc + ADDR_W'(4) : r_pc;
    w_state_nxt = r_state == IDLE  ? FETCH :
                  r_state == FETCH ? (redirect_valid ? (imem_ack ? FETCH : DRAIN) : (imem_ack ? ISSUE : FETCH)) :
                  r_state == ISSUE ? ((redirect_valid || w_hs) ? FETCH : ISSUE) :
                  (imem_ack ? FETCH : DRAIN);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc <= RESET_PC;
      r_addr <= RESET_PC;
      r_instr <= '0;
      r_dec_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc <= w_pc_nxt;
      if (w_state_nxt == FETCH) r_addr <= w_pc_nxt;
      if (w_cap) begin
        r_instr <= imem_rdata;
        r_dec_pc <= r_pc;
      end
    end
  end
  assign imem_req = (r_state == FETCH) || (r_state == DRAIN);
  assign imem_addr = r_addr;
  assign dec_valid = r_state == ISSUE;
  assign dec_instr = r_instr;
  assign dec_opcode = r_instr[INSTR_W-1 -: OPCODE_W];
  assign dec_pc = r_dec_pc;
`ifdef IFU_PERF_CNT_EN
  logic w_flush;
  assign w_flush = ((r_state == ISSUE) && redirect_valid && !dec_ready) ||
                   ((r_state == DRAIN) && imem_ack) ||
                   ((r_state == FETCH) && imem_ack && redirect_valid);
  ifu_perf_counters u_perf (
    .clk(clk),
    .rst(rst),
    .i_fetch_inc(w_hs),
    .i_flush_inc(w_flush),
    .o_fetch_cnt(perf_fetch_cnt),
    .o_flush_cnt(perf_flush_cnt)
  );
`else
`endif
endmodule
